// File: rtl/ee354_detour_debouncer.sv
// Push-button conditioner: two-flop synchronizer plus counter-driven Moore debouncer
// producing DPB (level), SCEN (one pulse per press) and MCEN (press + hold repeats; `DEBOUNCER_MCEN_EN).
module ee354_detour_debouncer #(
    parameter int N_DC = 20
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       PB,
    output logic       DPB,
    output logic       SCEN,
    output logic       MCEN,
    output logic [2:0] q_state
);

    typedef enum logic [2:0] {
        INI     = 3'b000,
        W84     = 3'b001,
        SCEN_ST = 3'b010,
        WS      = 3'b011,
        MCEN_ST = 3'b100,
        WFCR    = 3'b101
    } state_t;

    state_t            state;
    logic [N_DC-1:0]   cnt;
    logic [2:0]        flags;   // {DPB, SCEN, MCEN}, registered alongside the state
    logic              sync1;
    logic              pb_s;
    logic              cnt_full;

    assign cnt_full = (cnt == '1);
    assign {DPB, SCEN, MCEN} = flags;
    assign q_state = state;

    function automatic logic [2:0] dec(input state_t s);
        case (s)
            SCEN_ST: dec = 3'b111;
            WS:      dec = 3'b100;
            WFCR:    dec = 3'b100;
`ifdef DEBOUNCER_MCEN_EN
            MCEN_ST: dec = 3'b101;
`endif
            default: dec = 3'b000;
        endcase
    endfunction

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            pb_s  <= 1'b0;
        end else begin
            sync1 <= PB;
            pb_s  <= sync1;
        end
    end

    // Outputs are loaded with the decode of the state being entered, so they
    // change on the same edge as the state register and never follow PB directly.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INI;
            cnt   <= '0;
            flags <= 3'b000;
        end else begin
            case (state)
                INI: begin
                    cnt <= '0;
                    if (pb_s) begin
                        state <= W84;
                        flags <= dec(W84);
                    end
                end
                W84: begin
                    if (!pb_s) begin
                        state <= INI;
                        cnt   <= '0;
                        flags <= dec(INI);
                    end else if (cnt_full) begin
                        state <= SCEN_ST;
                        cnt   <= '0;
                        flags <= dec(SCEN_ST);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCEN_ST: begin
                    state <= WS;
                    cnt   <= '0;
                    flags <= dec(WS);
                end
                WS: begin
                    if (!pb_s) begin
                        state <= WFCR;
                        cnt   <= '0;
                        flags <= dec(WFCR);
                    end else if (cnt_full) begin
`ifdef DEBOUNCER_MCEN_EN
                        state <= MCEN_ST;
                        cnt   <= '0;
                        flags <= dec(MCEN_ST);
`else
                        cnt   <= cnt;   // saturate: no repeat pulses without the macro
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef DEBOUNCER_MCEN_EN
                MCEN_ST: begin
                    state <= WS;
                    cnt   <= '0;
                    flags <= dec(WS);
                end
`endif
                WFCR: begin
                    if (pb_s) begin
                        state <= WS;
                        cnt   <= '0;
                        flags <= dec(WS);
                    end else if (cnt_full) begin
                        state <= INI;
                        cnt   <= '0;
                        flags <= dec(INI);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= INI;
                    cnt   <= '0;
                    flags <= dec(INI);
                end
            endcase
        end
    end

endmodule
